// File: rtl/vid_decoder_if.sv
// rtl/vid_decoder_if.sv - composite video sample in, decoded sync/timing/luma out
interface vid_decoder_if;
  logic [10:0] RawVIn;
  logic        HS;
  logic        VS;
  logic [10:0] HPos;
  logic [8:0]  Line;
  logic        LOCK;
  logic [10:0] BlackLvl;
  logic [10:0] Luma;
  logic        ACTIVE;
  logic [2:0]  BurstPhase;

  // Video source side: drives samples, observes the decoded timing.
  modport master (
    output RawVIn,
    input  HS, VS, HPos, Line, LOCK, BlackLvl, Luma, ACTIVE, BurstPhase
  );

  // Decoder side.
  modport slave (
    input  RawVIn,
    output HS, VS, HPos, Line, LOCK, BlackLvl, Luma, ACTIVE, BurstPhase
  );
endinterface

// File: rtl/vid_decoder.sv
// rtl/vid_decoder.sv - composite video sync separator, line lock and black-relative luma
// Optional burst phase detector enabled by VID_DECODER_BURST_PHASE_EN.
module vid_decoder #(
  parameter logic [10:0] SYNC_THRESH = 11'd64,
  parameter int          HSYNC_MIN   = 40,
  parameter int          VSYNC_MIN   = 400,
  parameter int          LINE_LEN    = 1364,
  parameter int          LINE_TOL    = 8,
  parameter int          LOCK_LINES  = 4,
  parameter int          BLANK_OFS   = 20,
  parameter int          ACT_START   = 200,
  parameter int          ACT_END     = 1224
) (
  input  logic          CLK,
  input  logic          n_RES,
  vid_decoder_if.slave  vid
);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic [10:0] HMIN      = 11'(HSYNC_MIN);
  localparam logic [10:0] VMIN      = 11'(VSYNC_MIN);
  localparam logic [10:0] BOFS      = 11'(BLANK_OFS);
  localparam logic [10:0] ASTART    = 11'(ACT_START);
  localparam logic [10:0] AEND      = 11'(ACT_END);
  localparam logic [10:0] MISS_POS  = 11'(LINE_LEN + LINE_TOL + 1);
  localparam logic [11:0] PER_MIN   = 12'(LINE_LEN - LINE_TOL);
  localparam logic [11:0] PER_MAX   = 12'(LINE_LEN + LINE_TOL);
  localparam logic [7:0]  LOCK_LAST = 8'(LOCK_LINES - 1);

  logic [10:0] raw_q;
  logic [10:0] run_q, run_d;
  logic [10:0] hpos_q, hpos_d;
  logic [8:0]  line_q;
  logic        hs_q, vs_q;
  logic        lock_q;
  logic        active_q;
  logic [10:0] black_q;
  logic [10:0] luma_q, luma_d;
  logic        skip_q;
  logic [7:0]  good_q;
  state_t      state_q;

  logic        tip;
  logic        sync_end;
  logic        is_hs;
  logic        is_vs;
  logic [11:0] period;
  logic        in_tol;
  logic        chk_period;
  logic        act_win;

  assign tip      = raw_q < SYNC_THRESH;
  // run_q is non-zero exactly when the previous sample was a tip.
  assign sync_end = !tip && (run_q != 11'd0);
  assign is_vs    = sync_end && (run_q >= VMIN);
  assign is_hs    = sync_end && (run_q >= HMIN);

  assign period     = {1'b0, hpos_q} + 12'd1;
  assign in_tol     = (period >= PER_MIN) && (period <= PER_MAX);
  // Vsync and the line that follows it carry no meaningful line period.
  assign chk_period = is_hs && !is_vs && !skip_q;

  assign act_win = lock_q && (hpos_q >= ASTART) && (hpos_q <= AEND);

  always_comb begin
    run_d  = 11'd0;
    hpos_d = hpos_q;
    luma_d = 11'd0;
    if (tip) begin
      run_d = run_q + {10'd0, (run_q != 11'h7FF)};
    end
    if (is_hs) begin
      hpos_d = 11'd0;
    end else begin
      hpos_d = hpos_q + {10'd0, (hpos_q != 11'h7FF)};
    end
    if (act_win && (raw_q > black_q)) begin
      luma_d = raw_q - black_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (!n_RES) begin
      raw_q    <= 11'd0;
      run_q    <= 11'd0;
      hpos_q   <= 11'd0;
      line_q   <= 9'd0;
      hs_q     <= 1'b0;
      vs_q     <= 1'b0;
      lock_q   <= 1'b0;
      active_q <= 1'b0;
      black_q  <= 11'd0;
      luma_q   <= 11'd0;
      skip_q   <= 1'b0;
      good_q   <= 8'd0;
      state_q  <= ST_SEARCH;
    end else begin
      raw_q    <= vid.RawVIn;
      run_q    <= run_d;
      hpos_q   <= hpos_d;
      hs_q     <= is_hs;
      vs_q     <= is_vs;
      active_q <= act_win;
      luma_q   <= luma_d;

      if (is_vs) begin
        line_q <= 9'd0;
      end else if (is_hs) begin
        line_q <= line_q + 9'd1;
      end

      if (is_vs) begin
        skip_q <= 1'b1;
      end else if (is_hs) begin
        skip_q <= 1'b0;
      end

      if ((hpos_q == BOFS) && !tip) begin
        black_q <= raw_q;
      end

      case (state_q)
        ST_SEARCH: begin
          if (is_hs) begin
            state_q <= ST_TRACK;
            good_q  <= 8'd0;
          end
        end
        ST_TRACK: begin
          if (chk_period) begin
            if (!in_tol) begin
              good_q <= 8'd0;
            end else if (good_q == LOCK_LAST) begin
              state_q <= ST_LOCKED;
              lock_q  <= 1'b1;
              good_q  <= 8'd0;
            end else begin
              good_q <= good_q + 8'd1;
            end
          end
        end
        ST_LOCKED: begin
          // Drop lock on a bad period or when the expected sync never came.
          if ((chk_period && !in_tol) || (!is_hs && (hpos_q >= MISS_POS))) begin
            state_q <= ST_SEARCH;
            lock_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_SEARCH;
          lock_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef VID_DECODER_BURST_PHASE_EN
  localparam logic [10:0] BURST_START = 11'(BLANK_OFS + 8);
  localparam logic [10:0] BURST_END   = 11'(BLANK_OFS + 8 + 47);

  logic [2:0]  ph_q;
  logic [2:0]  burst_q;
  logic        seen_q;
  logic [10:0] raw_prev_q;
  logic        in_burst;
  logic        rise;

  assign in_burst = (hpos_q >= BURST_START) && (hpos_q <= BURST_END);
  assign rise     = (raw_q > black_q) && (raw_prev_q <= black_q);

  // ph_q tracks hpos_q mod 6 because both restart on the same HS.
  always_ff @(posedge CLK) begin
    if (!n_RES) begin
      ph_q       <= 3'd0;
      burst_q    <= 3'd0;
      seen_q     <= 1'b0;
      raw_prev_q <= 11'd0;
    end else begin
      raw_prev_q <= raw_q;
      if (is_hs) begin
        ph_q   <= 3'd0;
        seen_q <= 1'b0;
      end else begin
        ph_q <= (ph_q == 3'd5) ? 3'd0 : ph_q + 3'd1;
        if (in_burst && rise && !seen_q) begin
          burst_q <= ph_q;
          seen_q  <= 1'b1;
        end
      end
    end
  end

  assign vid.BurstPhase = burst_q;
`else
  assign vid.BurstPhase = 3'd0;
`endif

  assign vid.HS       = hs_q;
  assign vid.VS       = vs_q;
  assign vid.HPos     = hpos_q;
  assign vid.Line     = line_q;
  assign vid.LOCK     = lock_q;
  assign vid.BlackLvl = black_q;
  assign vid.Luma     = luma_q;
  assign vid.ACTIVE   = active_q;

endmodule

// File: tb/tb_vid_decoder.sv
// tb/tb_vid_decoder.sv - directed self-checking bench for vid_decoder
module tb_vid_decoder;

  logic CLK = 1'b0;
  logic n_RES = 1'b0;

  vid_decoder_if vif ();

  vid_decoder u_dut (
    .CLK   (CLK),
    .n_RES (n_RES),
    .vid   (vif)
  );

  always #5 CLK = ~CLK;

  int n_assert = 0;
  int n_fail   = 0;
  int hs_cnt   = 0;
  int vs_cnt   = 0;

  logic [10:0] rec_luma   [0:2047];
  logic        rec_active [0:2047];
  logic        rec_lock   [0:2047];

`ifdef VID_DECODER_BURST_PHASE_EN
  localparam logic [31:0] EXP_BURST = 32'd1;
`else
  localparam logic [31:0] EXP_BURST = 32'd0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_rec();
    for (int i = 0; i < 2048; i++) begin
      rec_luma[i]   = 'x;
      rec_active[i] = 1'bx;
      rec_lock[i]   = 1'bx;
    end
  endtask

  // Drive one sample, then observe outputs 1 time unit after the edge.
  task automatic tick(input logic [10:0] v);
    vif.RawVIn = v;
    @(posedge CLK);
    #1;
    if (vif.HS === 1'b1) hs_cnt++;
    if (vif.VS === 1'b1) vs_cnt++;
    rec_luma[vif.HPos]   = vif.Luma;
    rec_active[vif.HPos] = vif.ACTIVE;
    rec_lock[vif.HPos]   = vif.LOCK;
  endtask

  // Line sample idx maps to HPos idx-101 of the same line (HS lands at idx 101).
  function automatic logic [10:0] lvl(input int idx, input int tip, input int act, input bit flat);
    if (idx < tip) return 11'd0;
    if (flat) return 11'd300;
    if (idx >= 132 && idx <= 179) return (((idx - 132) / 3) % 2 == 0) ? 11'd400 : 11'd200;
    if (idx >= 250 && idx <= 1340) return 11'(act);
    return 11'd300;
  endfunction

  task automatic run_line(input int len, input int tip, input int act, input bit flat, input bit glitch);
    logic [10:0] v;
    clear_rec();
    for (int idx = 0; idx < len; idx++) begin
      v = lvl(idx, tip, act, flat);
      if (glitch && idx >= 600 && idx < 610) v = 11'd0;
      tick(v);
    end
  endtask

  initial begin
    vif.RawVIn = 11'd0;
    n_RES = 1'b0;
    for (int i = 0; i < 5; i++) tick(11'd0);
    chk("rst_hs", vif.HS, 0);
    chk("rst_vs", vif.VS, 0);
    chk("rst_hpos", vif.HPos, 0);
    chk("rst_line", vif.Line, 0);
    chk("rst_lock", vif.LOCK, 0);
    chk("rst_black", vif.BlackLvl, 0);
    chk("rst_luma", vif.Luma, 0);
    chk("rst_active", vif.ACTIVE, 0);
    chk("rst_burst", vif.BurstPhase, 0);

    n_RES = 1'b1;
    hs_cnt = 0;
    for (int i = 0; i < 50; i++) tick(11'd300);
    chk("rel_no_hs", hs_cnt, 0);
    chk("rel_hpos", vif.HPos, 50);

    run_line(1364, 100, 700, 1'b0, 1'b0);
    chk("unlocked_active", rec_active[600], 0);
    run_line(1364, 100, 700, 1'b0, 1'b0);
    run_line(1364, 100, 700, 1'b0, 1'b0);
    run_line(1364, 100, 700, 1'b0, 1'b0);
    chk("lock_after_4hs", vif.LOCK, 0);
    run_line(1364, 100, 700, 1'b0, 1'b0);
    chk("lock_after_5hs", vif.LOCK, 1);
    run_line(1364, 100, 700, 1'b0, 1'b0);
    chk("hs_pulses", hs_cnt, 6);
    chk("line_cnt6", vif.Line, 6);
    chk("hpos_eol", vif.HPos, 1262);
    chk("black", vif.BlackLvl, 300);
    chk("luma_mid", rec_luma[600], 400);
    chk("active_mid", rec_active[600], 1);
    chk("active_200", rec_active[200], 0);
    chk("active_201", rec_active[201], 1);
    chk("active_1225", rec_active[1225], 1);
    chk("luma_1225", rec_luma[1225], 400);
    chk("active_1226", rec_active[1226], 0);
    chk("luma_1226", rec_luma[1226], 0);
    chk("burst_phase", vif.BurstPhase, EXP_BURST);

    run_line(1364, 100, 700, 1'b0, 1'b1);
    chk("glitch_hs", hs_cnt, 7);
    chk("glitch_hpos", vif.HPos, 1262);
    chk("glitch_lock", vif.LOCK, 1);

    // The 500-CLK tip overruns the missed-sync limit, so lock is lost first.
    run_line(1364, 500, 300, 1'b1, 1'b0);
    chk("vs_cnt", vs_cnt, 1);
    chk("vs_hs_cnt", hs_cnt, 8);
    chk("vs_line", vif.Line, 0);
    chk("vs_hpos", vif.HPos, 862);
    chk("vs_lock", vif.LOCK, 0);
    for (int i = 0; i < 5; i++) run_line(1364, 100, 700, 1'b0, 1'b0);
    chk("relock_line", vif.Line, 5);
    chk("relock_lock", vif.LOCK, 1);

    run_line(1380, 100, 700, 1'b0, 1'b0);
    chk("long_pre_lock", vif.LOCK, 1);
    run_line(1364, 100, 700, 1'b0, 1'b0);
    chk("long_unlock", vif.LOCK, 0);
    for (int i = 0; i < 4; i++) run_line(1364, 100, 700, 1'b0, 1'b0);
    chk("relock2", vif.LOCK, 1);

    run_line(1372, 100, 250, 1'b0, 1'b0);
    chk("luma_dim", rec_luma[600], 0);
    chk("active_dim", rec_active[600], 1);
    run_line(1356, 100, 700, 1'b0, 1'b0);
    chk("tol_plus8", vif.LOCK, 1);
    run_line(1355, 100, 700, 1'b0, 1'b0);
    chk("tol_minus8", vif.LOCK, 1);
    run_line(1364, 100, 700, 1'b0, 1'b0);
    chk("tol_minus9", vif.LOCK, 0);
    for (int i = 0; i < 5; i++) run_line(1364, 100, 700, 1'b0, 1'b0);
    chk("relock3", vif.LOCK, 1);

    clear_rec();
    for (int i = 0; i < 1000; i++) tick(11'd300);
    chk("miss_lock_1372", rec_lock[1372], 1);
    chk("miss_lock_1375", rec_lock[1375], 0);
    chk("miss_hpos_sat", vif.HPos, 2047);
    chk("miss_lock", vif.LOCK, 0);
    chk("miss_active", vif.ACTIVE, 0);

    n_RES = 1'b0;
    tick(11'd300);
    chk("mid_rst_hpos", vif.HPos, 0);
    chk("mid_rst_line", vif.Line, 0);
    chk("mid_rst_black", vif.BlackLvl, 0);
    chk("mid_rst_burst", vif.BurstPhase, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
